// File: rtl/video_capture.sv
// video_capture: measures the geometry of incoming active video, locks once
// LOCK_FRAMES consecutive identical frames are seen, then streams RGB565
// pixels with start-of-frame and end-of-line markers. S1 registers the raw
// inputs; every output is registered from S2, giving a 2-cycle latency.
module video_capture #(
    parameter int LOCK_FRAMES = 2,
    parameter bit VS_POL      = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic        capture_en,
    input  logic        video_hs,
    input  logic        video_vs,
    input  logic        video_de,
    input  logic [23:0] video_rgb,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        data_sof,
    output logic        data_eol,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        locked,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [7:0]  LOCK_CNT = 8'(LOCK_FRAMES);
    localparam logic [10:0] CNT_MAX  = 11'd2047;
    localparam logic [10:0] DIM_MAX  = 11'd2046;

    // S1 input registers and their one-cycle-delayed copies for edge detection
    logic        hs1_r;
    logic        vs1_r;
    logic        de1_r;
    logic [23:0] rgb1_r;
    logic        vs_prev_r;
    logic        de_prev_r;

    // geometry measurement
    logic [10:0] pix_cnt_r;
    logic [10:0] line_cnt_r;
    logic [10:0] first_w_r;
    logic        consist_r;

    // control state
    state_t      state_r;
    logic [7:0]  good_cnt_r;
    logic [10:0] prev_w_r;
    logic [10:0] prev_h_r;
    logic [10:0] h_disp_r;
    logic [10:0] v_disp_r;
    logic        locked_r;
    logic        frame_err_r;
    logic        stream_r;
    logic        sof_pend_r;

    // S2 output registers
    logic [15:0] data_r;
    logic        valid_r;
    logic        sof_r;
    logic        eol_r;

    // combinational decode
    logic        fall_s;
    logic        bound_s;
    logic [10:0] lines_s;
    logic [10:0] fw_s;
    logic        same_s;
    logic        frame_ok_s;
    logic        match_s;
    logic [7:0]  nxt_cnt_s;
    logic        err_s;
    logic        vld_s;
    logic        unused_s;

    // hsync and the colour LSBs dropped by RGB565 are registered but unused
    assign unused_s = ^{hs1_r, rgb1_r[18:16], rgb1_r[9:8], rgb1_r[2:0]};

    // S1: register every input once
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            hs1_r     <= 1'b0;
            vs1_r     <= 1'b0;
            de1_r     <= 1'b0;
            rgb1_r    <= 24'd0;
            vs_prev_r <= 1'b0;
            de_prev_r <= 1'b0;
        end else begin
            hs1_r     <= video_hs;
            vs1_r     <= video_vs;
            de1_r     <= video_de;
            rgb1_r    <= video_rgb;
            vs_prev_r <= vs1_r;
            de_prev_r <= de1_r;
        end
    end

    // Frame/line events and the consistency verdict for the frame ending now
    always_comb begin
        fall_s  = de_prev_r & ~de1_r;
        bound_s = (vs1_r == VS_POL) && (vs_prev_r != VS_POL);

        // a line ending on the boundary cycle still belongs to the old frame
        if (fall_s && (line_cnt_r != CNT_MAX)) begin
            lines_s = line_cnt_r + 11'd1;
        end else begin
            lines_s = line_cnt_r;
        end

        if (fall_s && (line_cnt_r == 11'd0)) begin
            fw_s = pix_cnt_r;
        end else begin
            fw_s = first_w_r;
        end

        if (fall_s && (line_cnt_r != 11'd0) && (pix_cnt_r != first_w_r)) begin
            same_s = 1'b0;
        end else begin
            same_s = consist_r;
        end

        frame_ok_s = same_s
                     && (fw_s >= 11'd1) && (fw_s <= DIM_MAX)
                     && (lines_s >= 11'd1) && (lines_s <= DIM_MAX);
        match_s    = (fw_s == prev_w_r) && (lines_s == prev_h_r);

        if (!frame_ok_s) begin
            nxt_cnt_s = 8'd0;
        end else if (match_s && (good_cnt_r != 8'hFF)) begin
            nxt_cnt_s = good_cnt_r + 8'd1;
        end else if (match_s) begin
            nxt_cnt_s = good_cnt_r;
        end else begin
            nxt_cnt_s = 8'd1;
        end

        if (state_r == ST_LOCKED) begin
            err_s = (fall_s && (pix_cnt_r != h_disp_r))
                    || (bound_s && (lines_s != v_disp_r));
        end else begin
            err_s = 1'b0;
        end

        // stream only whole frames: the first boundary seen while locked opens it
        if (capture_en && (state_r == ST_LOCKED) && de1_r && !err_s) begin
            vld_s = stream_r || bound_s;
        end else begin
            vld_s = 1'b0;
        end
    end

    // Pixel/line counters and per-frame width consistency tracking
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            pix_cnt_r  <= 11'd0;
            line_cnt_r <= 11'd0;
            first_w_r  <= 11'd0;
            consist_r  <= 1'b0;
        end else begin
            if (fall_s) begin
                pix_cnt_r <= 11'd0;
            end else if (de1_r && (pix_cnt_r != CNT_MAX)) begin
                pix_cnt_r <= pix_cnt_r + 11'd1;
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end

            if (bound_s) begin
                line_cnt_r <= 11'd0;
                first_w_r  <= 11'd0;
                consist_r  <= 1'b1;
            end else begin
                line_cnt_r <= lines_s;
                first_w_r  <= fw_s;
                consist_r  <= same_s;
            end
        end
    end

    // Lock FSM with registered status outputs and locked geometry
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            good_cnt_r  <= 8'd0;
            prev_w_r    <= 11'd0;
            prev_h_r    <= 11'd0;
            h_disp_r    <= 11'd0;
            v_disp_r    <= 11'd0;
            locked_r    <= 1'b0;
            frame_err_r <= 1'b0;
            stream_r    <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (!capture_en) begin
                state_r    <= ST_IDLE;
                good_cnt_r <= 8'd0;
                locked_r   <= 1'b0;
                stream_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_WAIT_VS;
                    end
                    ST_WAIT_VS: begin
                        if (bound_s) begin
                            state_r    <= ST_MEASURE;
                            good_cnt_r <= 8'd0;
                        end
                    end
                    ST_MEASURE: begin
                        if (bound_s) begin
                            prev_w_r   <= fw_s;
                            prev_h_r   <= lines_s;
                            good_cnt_r <= nxt_cnt_s;
                            if ((nxt_cnt_s != 8'd0) && (nxt_cnt_s >= LOCK_CNT)) begin
                                state_r  <= ST_LOCKED;
                                locked_r <= 1'b1;
                                stream_r <= 1'b0;
                                h_disp_r <= fw_s;
                                v_disp_r <= lines_s;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (err_s) begin
                            state_r     <= ST_MEASURE;
                            good_cnt_r  <= 8'd0;
                            locked_r    <= 1'b0;
                            stream_r    <= 1'b0;
                            frame_err_r <= 1'b1;
                        end else if (bound_s) begin
                            stream_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        locked_r <= 1'b0;
                        stream_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // S2: RGB565 pixel, strobes and frame/line markers
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            data_r     <= 16'd0;
            valid_r    <= 1'b0;
            sof_r      <= 1'b0;
            eol_r      <= 1'b0;
            sof_pend_r <= 1'b0;
        end else begin
            data_r  <= {rgb1_r[23:19], rgb1_r[15:10], rgb1_r[7:3]};
            valid_r <= vld_s;
            sof_r   <= vld_s && (sof_pend_r || bound_s);
            // next pixel (entering S1 now) has DE low: this one ends the line
            eol_r   <= vld_s && !video_de;
            if (!capture_en || (state_r != ST_LOCKED)) begin
                sof_pend_r <= 1'b0;
            end else if (vld_s) begin
                sof_pend_r <= 1'b0;
            end else if (bound_s) begin
                sof_pend_r <= 1'b1;
            end else begin
                sof_pend_r <= sof_pend_r;
            end
        end
    end

    assign data_out   = data_r;
    assign data_valid = valid_r;
    assign data_sof   = sof_r;
    assign data_eol   = eol_r;
    assign h_disp     = h_disp_r;
    assign v_disp     = v_disp_r;
    assign locked     = locked_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed 8x4 video frames; expected pixels are queued by
// the stimulus and popped by an independent output monitor.
module tb_video_capture;

    logic        clk;
    logic        sys_rst;
    logic        capture_en;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_sof;
    logic        data_eol;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        locked;
    logic        frame_err;

    video_capture #(.LOCK_FRAMES(2), .VS_POL(1'b1)) dut (
        .pixel_clk (clk),
        .sys_rst   (sys_rst),
        .capture_en(capture_en),
        .video_hs  (video_hs),
        .video_vs  (video_vs),
        .video_de  (video_de),
        .video_rgb (video_rgb),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_sof  (data_sof),
        .data_eol  (data_eol),
        .h_disp    (h_disp),
        .v_disp    (v_disp),
        .locked    (locked),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [15:0] d;
        bit          sof;
        bit          eol;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] rgb_tab [8];
    logic [15:0] exp_tab [8];
    int          cyc;
    int          n_chk;
    int          n_pass;
    int          n_valid;
    int          n_sof;
    int          n_eol;
    int          n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops one expectation per valid pixel
    initial begin
        exp_t e;
        bit   err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                n_valid++;
                if (data_sof) n_sof++;
                if (data_eol) n_eol++;
                check(exp_q.size() > 0, "valid_expected", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(data_out == e.d, "data_out", 32'(data_out), 32'(e.d));
                    check(data_sof == e.sof, "data_sof", 32'(data_sof), 32'(e.sof));
                    check(data_eol == e.eol, "data_eol", 32'(data_eol), 32'(e.eol));
                    check((cyc - e.cyc) == 2, "latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            if (frame_err) begin
                n_err++;
                check(!err_prev, "err_pulse_width", 32'(err_prev), 32'd0);
            end
            if (err_prev) begin
                check(!locked, "unlock_after_err", 32'(locked), 32'd0);
            end
            err_prev = frame_err;
        end
    end

    // One frame: vsync pulse, short blanking, then h lines of 8 pixels
    // (line bad_line has 7). abort_mode 1 drops capture_en and 2 pulses
    // sys_rst at pixel 4 of abort_line; pixels from 3 onward never stream.
    task automatic drive_frame(input int h, input int bad_line, input bit stream,
                               input int abort_mode, input int abort_line);
        bit   first;
        bit   live;
        exp_t e;
        int   w;
        first = 1'b1;
        live  = stream;
        video_vs = 1'b1;
        step;
        step;
        video_vs = 1'b0;
        repeat (3) step;
        for (int l = 0; l < h; l++) begin
            w = (l == bad_line) ? 7 : 8;
            video_hs = 1'b1;
            for (int p = 0; p < w; p++) begin
                video_de  = 1'b1;
                video_rgb = rgb_tab[p];
                if ((abort_mode != 0) && (l == abort_line) && (p >= 3)) live = 1'b0;
                if ((abort_mode == 1) && (l == abort_line) && (p == 4)) capture_en = 1'b0;
                if ((abort_mode == 2) && (l == abort_line) && (p == 4)) sys_rst = 1'b1;
                if ((abort_mode == 2) && (l == abort_line) && (p == 5)) sys_rst = 1'b0;
                if (live) begin
                    e.d   = exp_tab[p];
                    e.sof = first;
                    e.eol = (p == w - 1);
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    first = 1'b0;
                end
                step;
                if ((abort_mode == 1) && (l == abort_line) && (p == 4)) begin
                    check(!locked, "unlock_on_disable", 32'(locked), 32'd0);
                    check(!data_valid, "valid_off_on_disable", 32'(data_valid), 32'd0);
                end
                if ((abort_mode == 2) && (l == abort_line) && (p == 4)) begin
                    check(!data_valid && !data_sof && !data_eol && !frame_err,
                          "rst_strobes", {data_valid, data_sof, data_eol, frame_err}, 32'd0);
                    check(data_out == 16'd0, "rst_data_out", 32'(data_out), 32'd0);
                    check(!locked, "rst_locked", 32'(locked), 32'd0);
                    check(h_disp == 11'd0 && v_disp == 11'd0, "rst_disp",
                          {h_disp, v_disp}, 32'd0);
                end
            end
            video_de = 1'b0;
            video_hs = 1'b0;
            if (l == bad_line) live = 1'b0;
            repeat (4) step;
        end
    endtask

    initial begin
        rgb_tab[0] = 24'hFF8040; exp_tab[0] = 16'hFC08;
        rgb_tab[1] = 24'h000000; exp_tab[1] = 16'h0000;
        rgb_tab[2] = 24'hFFFFFF; exp_tab[2] = 16'hFFFF;
        rgb_tab[3] = 24'hF80000; exp_tab[3] = 16'hF800;
        rgb_tab[4] = 24'h00FC00; exp_tab[4] = 16'h07E0;
        rgb_tab[5] = 24'h0000F8; exp_tab[5] = 16'h001F;
        rgb_tab[6] = 24'h070307; exp_tab[6] = 16'h0000;
        rgb_tab[7] = 24'h123456; exp_tab[7] = 16'h11AA;
        n_chk = 0; n_pass = 0; n_valid = 0; n_sof = 0; n_eol = 0; n_err = 0;

        sys_rst = 1'b1; capture_en = 1'b0;
        video_hs = 1'b0; video_vs = 1'b0; video_de = 1'b0; video_rgb = 24'd0;
        repeat (3) step;
        check(!data_valid && !data_sof && !data_eol && !frame_err && !locked,
              "reset_flags", {data_valid, data_sof, data_eol, frame_err, locked}, 32'd0);
        check(data_out == 16'd0, "reset_data_out", 32'(data_out), 32'd0);
        check(h_disp == 11'd0 && v_disp == 11'd0, "reset_disp", {h_disp, v_disp}, 32'd0);
        sys_rst = 1'b0;
        capture_en = 1'b1;
        step; step;

        // initial lock: boundary 3 locks, frame 4 streams
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(!locked, "no_lock_at_b2", 32'(locked), 32'd0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(locked, "lock_at_b3", 32'(locked), 32'd1);
        check(h_disp == 11'd8, "h_disp", 32'(h_disp), 32'd8);
        check(v_disp == 11'd4, "v_disp", 32'(v_disp), 32'd4);
        n_valid = 0; n_sof = 0; n_eol = 0;
        drive_frame(4, -1, 1'b1, 0, 0);
        check(n_valid == 32, "frame_valid_count", 32'(n_valid), 32'd32);
        check(n_sof == 1, "frame_sof_count", 32'(n_sof), 32'd1);
        check(n_eol == 4, "frame_eol_count", 32'(n_eol), 32'd4);
        check(exp_q.size() == 0, "drain_f4", 32'(exp_q.size()), 32'd0);

        // short line while locked, then relock after two good frames
        drive_frame(4, 1, 1'b1, 0, 0);
        check(n_err == 1, "width_err_pulse", 32'(n_err), 32'd1);
        check(!locked, "unlock_width_err", 32'(locked), 32'd0);
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(!locked, "no_early_relock", 32'(locked), 32'd0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(locked, "relock_width", 32'(locked), 32'd1);

        // five-line frame while locked: error at the next boundary
        drive_frame(5, -1, 1'b1, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(n_err == 2, "height_err_pulse", 32'(n_err), 32'd2);
        check(!locked, "unlock_height_err", 32'(locked), 32'd0);
        check(h_disp == 11'd8 && v_disp == 11'd4, "disp_retained",
              {h_disp, v_disp}, {11'd8, 11'd4});
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(locked, "relock_height", 32'(locked), 32'd1);

        // capture_en dropped mid-line, then a full relock sequence
        drive_frame(4, -1, 1'b1, 1, 1);
        check(exp_q.size() == 0, "drain_disable", 32'(exp_q.size()), 32'd0);
        capture_en = 1'b1;
        step; step;
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(locked, "relock_enable", 32'(locked), 32'd1);

        // reset mid-frame while streaming; first frame after reset is silent
        drive_frame(4, -1, 1'b1, 2, 2);
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        drive_frame(4, -1, 1'b0, 0, 0);
        check(locked, "relock_reset", 32'(locked), 32'd1);
        n_sof = 0;
        drive_frame(4, -1, 1'b1, 0, 0);
        check(n_sof == 1, "sof_after_reset", 32'(n_sof), 32'd1);
        repeat (4) step;
        check(exp_q.size() == 0, "drain_final", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 The block SHALL have parameter LOCK_FRAMES, default 2, giving the number of consecutive identical frames required to lock.
REQ-002 The block SHALL have parameter VS_POL, default 1, giving the active level of video_vs.
REQ-003 The block SHALL have port pixel_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port capture_en, input, 1 bit: enables measuring and streaming.
REQ-006 The block SHALL have ports video_hs, video_vs and video_de, input, 1 bit each: incoming sync and data-enable.
REQ-007 The block SHALL have port video_rgb, input, 24 bits: pixel as {R[7:0],G[7:0],B[7:0]}.
REQ-008 The block SHALL have port data_out, output, 16 bits: RGB565 pixel.
REQ-009 The block SHALL have ports data_valid, data_sof and data_eol, output, 1 bit each: pixel strobe, first pixel of frame, and last pixel of line.
REQ-010 The block SHALL have ports h_disp and v_disp, output, 11 bits each: locked active width and height.
REQ-011 The block SHALL have ports locked and frame_err, output, 1 bit each: lock status and a 1-cycle error pulse.

Function
REQ-012 All inputs SHALL be registered once (stage S1), and outputs SHALL be registered from stage S2; input-to-data_out latency SHALL be exactly 2 cycles.
REQ-013 data_out SHALL be {R[7:3],G[7:2],B[7:3]}, truncated with no rounding.
REQ-014 A frame boundary SHALL be the S1 transition of video_vs into its active level (VS_POL); video_hs SHALL be ignored except for being registered.
REQ-015 The pixel counter SHALL increment on each S1 DE-high cycle, clear on each DE falling edge, and saturate at 2047.
REQ-016 The line counter SHALL increment on each DE falling edge, clear at each frame boundary, and saturate at 2047.
REQ-017 The FSM SHALL have states IDLE, WAIT_VS, MEASURE and LOCKED.
REQ-018 IDLE -> WAIT_VS when capture_en=1; any state -> IDLE on the cycle after capture_en=0.
REQ-019 WAIT_VS -> MEASURE at the first frame boundary.
REQ-020 In MEASURE, a frame SHALL be consistent when every line width equals the first line width, width is 1..2046, and line count is 1..2046.
REQ-021 In MEASURE, the consistent-frame count SHALL increment at each boundary when the frame is consistent and matches the previous frame's width/height, and SHALL otherwise reset to 1 (consistent frame) or 0 (inconsistent frame).
REQ-022 MEASURE -> LOCKED at the boundary where the count reaches LOCK_FRAMES; h_disp/v_disp SHALL load the measured values on that same cycle.
REQ-023 In LOCKED, a line width not equal to h_disp, detected at DE falling, or a line count not equal to v_disp, detected at the boundary, SHALL pulse frame_err for 1 cycle and transition to MEASURE on the next cycle with the count at 0.
REQ-024 data_valid SHALL be 1 only for S2 DE-high pixels while in LOCKED with capture_en=1, and only from the first frame boundary after entering LOCKED; a partial frame SHALL never be streamed.
REQ-025 data_sof SHALL accompany the first valid pixel after each boundary.
REQ-026 data_eol SHALL be 1 when S2 DE=1 and S1 DE=0, qualified by data_valid.
REQ-027 After leaving LOCKED, data_valid SHALL be 0 from the next cycle; already-emitted pixels SHALL not be retracted.
REQ-028 locked SHALL be 1 exactly while the FSM is in LOCKED; h_disp/v_disp SHALL hold their last locked values after unlock.
REQ-029 A frame boundary and a DE falling edge in the same cycle SHALL count that line toward the ending frame.
REQ-030 data_out SHALL be don't-care when data_valid=0 but SHALL still be registered.

Reset
REQ-031 When sys_rst=1, the block SHALL, on the next clock edge: enter IDLE; clear all counters and pipeline registers; drive data_out=0, data_valid=0, data_sof=0, data_eol=0, h_disp=0, v_disp=0, locked=0, frame_err=0.
REQ-032 Reset SHALL take priority over every other event, including mid-line.
REQ-033 After reset, the block SHALL require a new WAIT_VS/MEASURE sequence before streaming.

Verification
REQ-034 Scenario: 8x4 active frames, repeated, capture_en=1 -> locked=1 at the 3rd boundary (LOCK_FRAMES=2), h_disp=8, v_disp=4; streaming from the 4th frame with 32 valid pixels, 1 sof and 4 eol per frame.
REQ-035 Scenario: video_rgb=24'hFF8040 while locked -> data_out=16'hFC08, exactly 2 cycles after the input.
REQ-036 Scenario: while locked, one line of width 7 -> frame_err pulse at that DE falling, locked=0 next cycle, data_valid=0 thereafter; relock after 2 good frames.
REQ-037 Scenario: while locked, a frame with 5 lines -> frame_err at the boundary and unlock; h_disp=8 and v_disp=4 are retained.
REQ-038 Scenario: capture_en dropped mid-line -> data_valid=0 from the next cycle and state IDLE; on re-enable, no sof until lock is re-established.
REQ-039 Scenario: sys_rst asserted mid-frame while locked -> all outputs 0 on the next edge; the first frame after reset is not streamed.
